// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state codes and sizing helpers.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // The step counter must be able to hold WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_remainder_reg.sv
// Combined {remainder,quotient} shift register with the restoring trial subtractor.
module div_remainder_reg
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [2*WIDTH-1:0] rq;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic               fits;

    // Shift the next dividend bit into the partial remainder, then try the subtraction.
    assign trial   = {rq[2*WIDTH-1:WIDTH], rq[WIDTH-1]};
    assign diff    = trial - {1'b0, divisor};
    assign fits    = (trial >= {1'b0, divisor});
    assign rem_nxt = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_nxt = {rq[WIDTH-2:0], fits};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rq <= '0;
        else if (load)
            rq <= {{WIDTH{1'b0}}, dividend};
        else if (step)
            rq <= {rem_nxt, quo_nxt};
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, registered results.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend_in,
    input  logic [WIDTH-1:0] Divisor_in,
    output logic             Busy,
    output logic             Ready,
    output logic             DivZero,
    output logic [WIDTH-1:0] Quotient_out,
    output logic [WIDTH-1:0] Remainder_out
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic             accept;
    logic             iter;
    logic             last;

    assign iter   = (state == S_ITER);
    assign accept = Start && ((state == S_IDLE) || (state == S_DONE));
    assign last   = iter && (cnt == CW'(WIDTH - 1));
    assign Busy   = iter;
    assign Ready  = (state == S_DONE);

    div_remainder_reg #(.WIDTH(WIDTH)) u_rq (
        .clk      (clk),
        .rst_n    (Reset),
        .load     (accept),
        .step     (iter),
        .dividend (Dividend_in),
        .divisor  (dvsr),
        .rem_nxt  (rem_nxt),
        .quo_nxt  (quo_nxt)
    );

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            dvsr          <= '0;
            Quotient_out  <= '0;
            Remainder_out <= '0;
            DivZero       <= 1'b0;
        end else if (accept) begin
            dvsr <= Divisor_in;
            cnt  <= '0;
            // A zero divisor skips iteration and reports the conventional all-ones quotient.
            if (Divisor_in == '0) begin
                state         <= S_DONE;
                Quotient_out  <= '1;
                Remainder_out <= Dividend_in;
                DivZero       <= 1'b1;
            end else begin
                state         <= S_ITER;
                Quotient_out  <= '0;
                Remainder_out <= '0;
                DivZero       <= 1'b0;
            end
        end else if (iter) begin
            cnt <= cnt + CW'(1);
            if (last) begin
                state         <= S_DONE;
                Quotient_out  <= quo_nxt;
                Remainder_out <= rem_nxt;
            end
        end else if (state != S_DONE) begin
            state <= S_IDLE;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver queues expected results, monitor checks on Ready.
module tb_seq_divider;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
        int               lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             Reset = 1'b0;
    logic             Start = 1'b0;
    logic [WIDTH-1:0] Dividend_in = '0;
    logic [WIDTH-1:0] Divisor_in = '0;
    logic             Busy;
    logic             Ready;
    logic             DivZero;
    logic [WIDTH-1:0] Quotient_out;
    logic [WIDTH-1:0] Remainder_out;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .Reset         (Reset),
        .Start         (Start),
        .Dividend_in   (Dividend_in),
        .Divisor_in    (Divisor_in),
        .Busy          (Busy),
        .Ready         (Ready),
        .DivZero       (DivZero),
        .Quotient_out  (Quotient_out),
        .Remainder_out (Remainder_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    // Reference model: plain integer division, with the divide-by-zero convention.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = WIDTH + 1;
        end
        return e;
    endfunction

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int guard = 0;
        @(posedge clk); #1;
        while (Busy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        exp_q.push_back(model(a, b));
        Start = 1'b1; Dividend_in = a; Divisor_in = b;
        @(posedge clk); #1;
        Start = 1'b0;
        Dividend_in = $urandom; Divisor_in = $urandom;
    endtask

    task automatic wait_done();
        for (int i = 0; i < WIDTH + 10; i++) begin
            @(negedge clk);
            if (Ready) return;
        end
        chk("wait_done_timeout", 64'd1, 64'd0);
    endtask

    // Monitor: arms on an accepted Start, compares when Ready is next seen.
    initial begin
        bit   armed = 1'b0;
        int   lat = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!Reset) begin
                armed = 1'b0;
            end else begin
                if (armed) begin
                    lat++;
                    if (Ready) begin
                        armed = 1'b0;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_result", 64'd1, 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("quotient", 64'(Quotient_out), 64'(e.q));
                            chk("remainder", 64'(Remainder_out), 64'(e.r));
                            chk("divzero", 64'(DivZero), 64'(e.dz));
                            chk("latency", 64'(lat), 64'(e.lat));
                        end
                    end else if (lat == 2) begin
                        chk("busy_flag", 64'(Busy), 64'd1);
                        chk("cleared_outs", {Quotient_out, Remainder_out}, 64'd0);
                        chk("cleared_dz", 64'(DivZero), 64'd0);
                    end else if (lat > WIDTH + 8) begin
                        armed = 1'b0;
                        chk("ready_timeout", 64'd1, 64'd0);
                    end
                end
                if (Start && !Busy) begin
                    armed = 1'b1;
                    lat = 0;
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] a, b;
        #12;
        chk("reset_outs", {Quotient_out, Remainder_out}, 64'd0);
        chk("reset_flags", {61'd0, Busy, Ready, DivZero}, 64'd0);
        @(posedge clk); #1 Reset = 1'b1;

        do_op(32'd100, 32'd7);              wait_done();
        do_op(32'hFFFF_FFFF, 32'd1);        wait_done();
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
        do_op(32'd5, 32'd9);                wait_done();
        do_op(32'd0, 32'd3);                wait_done();
        do_op(32'd1234, 32'd0);             wait_done();

        // Start pulse mid-iteration must be ignored.
        do_op(32'd1000, 32'd33);
        repeat (5) @(posedge clk);
        #1 Start = 1'b1; Dividend_in = 32'd99; Divisor_in = 32'd2;
        @(posedge clk); #1 Start = 1'b0;
        wait_done();
        // Back-to-back from DONE, including a zero divisor that keeps Ready high.
        do_op(32'd50, 32'd6);               wait_done();
        do_op(32'd77, 32'd0);               wait_done();
        do_op(32'd9, 32'd4);                wait_done();

        // Reset at iteration 10 aborts with no result.
        do_op(32'd123456, 32'd789);
        repeat (9) @(posedge clk);
        #1 Reset = 1'b0;
        #1;
        chk("abort_outs", {Quotient_out, Remainder_out}, 64'd0);
        chk("abort_flags", {61'd0, Busy, Ready, DivZero}, 64'd0);
        void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        #1 Reset = 1'b1;
        do_op(32'd77, 32'd7);               wait_done();

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 5) == 0) a = a >> $urandom_range(0, 31);
            do_op(a, b);
            wait_done();
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
